// File: rtl/hilo_muldiv.sv
// MIPS HI/LO register pair with a single-cycle multiplier and a 32-step restoring divider.
// busy covers an in-flight divide; done pulses once whenever an op rewrites HI/LO.
module hilo_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_signed_div;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH+1:0]  trial;

  assign is_signed_div = (op == 2'b10);
  assign abs_a = (is_signed_div && DataA[WIDTH-1]) ? -DataA : DataA;
  assign abs_b = (is_signed_div && DataB[WIDTH-1]) ? -DataB : DataB;

  // The low 2*WIDTH bits of a sign-extended product equal the signed product.
  assign prod_u = {{WIDTH{1'b0}}, DataA} * {{WIDTH{1'b0}}, DataB};
  assign prod_s = {{WIDTH{DataA[WIDTH-1]}}, DataA} * {{WIDTH{DataB[WIDTH-1]}}, DataB};

  // One restoring step; one extra guard bit keeps the trial sign exact.
  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (!op[1]) begin
            {hi_d, lo_d} = op[0] ? prod_u : prod_s;
            done_d       = 1'b1;
          end else begin
            quo_d   = abs_a;
            rem_d   = '0;
            dvs_d   = abs_b;
            // A zero divisor yields all-ones in the quotient regardless of sign.
            qneg_d  = is_signed_div && (DataA[WIDTH-1] ^ DataB[WIDTH-1]) && (DataB != '0);
            rneg_d  = is_signed_div && DataA[WIDTH-1];
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = StDiv;
          end
        end else begin
          if (mthi) hi_d = DataA;
          if (mtlo) lo_d = DataA;
        end
      end
      StDiv: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DIV_STEPS - 1)) state_d = StFix;
        end
      end
      StFix: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (!flush) begin
          lo_d   = qneg_q ? -quo_q : quo_q;
          hi_d   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised scoreboard bench for hilo_muldiv: expected HI/LO come from plain 64-bit arithmetic.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  hilo_muldiv #(.WIDTH(32), .DIV_STEPS(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .DataA(DataA),
    .DataB(DataB),
    .flush(flush),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics straight from integer arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) r = sa * sb;
    else if (o == 2'b01) r = {32'b0, a} * {32'b0, b};
    else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
    else if (o == 2'b10) r = {32'(sa % sb), 32'(sa / sb)};
    else r = {a % b, a / b};
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hilo", {hi, lo}, mon_e);
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit mv_same, input bit mv_busy);
    logic [63:0] e;
    int cyc;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; DataA = a; DataB = b;
    mthi = mv_same; mtlo = mv_same;
    e = model(o, a, b);
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      mthi = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (o[1]) check("busy_during_div", {63'b0, busy}, 64'd1);
      if (mv_busy && i == 2) begin
        mthi = 1'b1;
        DataA = 32'h0000_1234;
      end
      cyc++;
    end
    check("done_seen", {63'b0, got}, 64'd1);
    check("latency", 64'(cyc), o[1] ? 64'd33 : 64'd0);
    check("busy_after_done", {63'b0, busy}, 64'd0);
  endtask

  task automatic do_move(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    mthi = to_hi; mtlo = !to_hi; DataA = v;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (to_hi) m_hi = v;
    else m_lo = v;
    check("move", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [31:0] pool [6];
    logic [31:0] ra, rb;
    pool[0] = 32'h8000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h0;
    pool[3] = 32'h1;         pool[4] = 32'h7FFF_FFFF; pool[5] = 32'hFFFF_FFF9;

    repeat (2) @(negedge clk);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;

    do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_7_2", {hi, lo}, {32'd1, 32'd3});
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("div_7_m2", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("multu", {hi, lo}, {32'h2, 32'hFFFF_FFFA});
    do_op(2'b10, 32'h10, 32'd0, 1'b0, 1'b0);
    check("div_by_zero", {hi, lo}, {32'h10, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});

    // Abort a divide mid-flight: no done, HI/LO keep the previous result.
    @(negedge clk);
    start = 1'b1; op = 2'b11; DataA = 32'd100; DataB = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_keep", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    check("flush_keep_later", {hi, lo}, {m_hi, m_lo});
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

    // Flush in IDLE suppresses a simultaneous start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; DataA = 32'd5; DataB = 32'd5;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_nodone", {63'b0, done}, 64'd0);
    check("idle_flush_keep", {hi, lo}, {m_hi, m_lo});

    do_op(2'b10, 32'd1000, 32'd3, 1'b0, 1'b1);
    check("mthi_dropped_busy", {32'b0, hi}, 64'd1);
    do_move(1'b0, 32'h0000_ABCD);
    do_move(1'b1, 32'hCAFE_0001);
    do_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0);
    check("start_beats_move", {hi, lo}, {32'd0, 32'd42});

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = rb & 32'h0000_000F;
      do_op(2'($urandom_range(0, 3)), ra, rb, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) do_move($urandom_range(0, 1) == 1, $urandom);
    end

    // Asynchronous reset mid-divide clears everything immediately.
    @(negedge clk);
    start = 1'b1; op = 2'b10; DataA = 32'd12345; DataB = 32'd17;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hi", {32'b0, hi}, 64'd0);
    check("rst_mid_lo", {32'b0, lo}, 64'd0);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_done", {63'b0, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_late_done", {hi, lo}, 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the MIPS HI/LO register pair.
- Sits in the EX stage beside the single-cycle ALU. It accepts mult/multu/div/divu/mthi/mtlo from EX and serves mfhi/mflo reads.
- Divide is the inverse of the ALU's multiply path and runs as an iterative 32-step restoring divider.
- Raises busy so the hazard unit stalls dependent HI/LO accesses.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- DIV_STEPS, 32, number of divide iterations. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to launch op with DataA/DataB
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- DataA  input  32  rs operand (dividend / multiplicand)
- DataB  input  32  rt operand (divisor / multiplier)
- flush  input  1  abort in-flight divide (branch/exception kill)
- mthi  input  1  write DataA into HI
- mtlo  input  1  write DataA into LO
- busy  output  1  divide in progress
- done  output  1  one-cycle pulse when HI/LO updated by an op
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hi = 0, lo = 0, busy = 0, done = 0.
  - FSM goes to IDLE; internal quotient, remainder and counter are cleared.
  - Reset asserted mid-divide discards the operation.
- FSM states: IDLE, DIV, FIX.
- IDLE:
  - start with op=mult/multu at edge k: 64-bit product (signed for mult via $signed, unsigned for multu) is written at edge k. {hi,lo} = product, done=1 for the cycle after edge k. FSM stays in IDLE.
  - start with op=div/divu at edge k:
    - Latch the absolute values (div) or raw values (divu).
    - Latch the sign of the quotient (signA^signB) and the sign of the remainder (signA).
    - Set counter = 0, busy = 1, and go to DIV.
- DIV:
  - Each edge performs one restoring step: shift {rem,quo} left 1, trial-subtract the divisor from rem, keep the result if it is non-negative and set the quotient bit.
  - After the step with counter = DIV_STEPS-1, go to FIX.
- FIX (one edge):
  - Apply the signs: quotient negated if the quotient sign is set; remainder negated if the dividend sign is set.
  - Write lo = quotient, hi = remainder, busy = 0, done = 1 for one cycle, and return to IDLE.
- Latency: for a div started at edge k, busy is high from after edge k through edge k+33. HI/LO are updated and done is high after edge k+33 (34 edges total).
- Divide by zero:
  - No trap. lo = 0xFFFFFFFF, hi = dividend (original signed value).
  - Same latency as a normal divide.
- Overflow case 0x80000000 / 0xFFFFFFFF (div):
  - lo = 0x80000000, hi = 0.
  - Falls out of the magnitude math with WIDTH+1-bit internal remainder; no special case required, but must match.
- start while busy: ignored; no queueing. The hazard unit must not issue it.
- mthi/mtlo:
  - Take effect at the next edge only when busy = 0 and no start is accepted in the same cycle.
  - start together with mthi/mtlo in the same cycle: start wins, and the move is dropped.
  - While busy = 1: dropped.
- flush:
  - If in DIV or FIX: return to IDLE next edge, busy = 0, done = 0, hi/lo unchanged.
  - If in IDLE: no effect, and any start in the same cycle is suppressed.
- hi/lo outputs are the registers directly. mfhi/mflo during busy read stale values, so the stall is the consumer's job.
- No combinational path from inputs to outputs.

Test Plan:
- divu, DataA=7, DataB=2, start at edge 0 -> busy 1 for edges 1..33; done pulse after edge 33; lo=3, hi=1.
- div, DataA=0xFFFFFFF9 (-7), DataB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); also 7/-2 -> lo=0xFFFFFFFD, hi=1.
- mult, DataA=0xFFFFFFFE, DataB=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle; multu with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div by zero, DataA=0x00000010, DataB=0 -> lo=0xFFFFFFFF, hi=0x10 after 34 edges; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start divu 100/7, pulse flush at edge 10 -> busy=0 at edge 11, no done, hi/lo keep prior values; then a new divu 100/7 -> lo=14, hi=2.
- Start div, drop rst_n at edge 5 (mid-cycle) -> hi=lo=0 and busy=0 immediately. mthi(0x1234) during busy is ignored; after done, mtlo(0xABCD) -> lo=0xABCD next edge.
